sdram_sync_ctrl: RTL and testbench

Single-port SDRAM controller that services word requests from a slow client clock domain running in lock-step with the 64 MHz SDRAM clock. It sits between client logic (the RAM test, later the Gameboy core) and the 16-bit, 2-bank, 11-bit-address SDRAM pins. The client's tristate SB_IO wrapper connects the controller to the pins. Every `sync` pulse opens one 8-cycle window, which carries exactly one of READ, WRITE or AUTO REFRESH.

---
 rtl/sdram_pkg.sv | 48 ++++
 rtl/sdram_init_seq.sv | 111 +++++++++++
 rtl/sdram_sync_ctrl.sv | 157 +++++++++++++++
 tb/tb_sdram_sync_ctrl.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sdram_pkg.sv
// -----------------------------------------------------------------------------
// sdram_pkg
// Shared definitions for the SDRAM controller:
//   - 4-bit SDRAM command encodings, packed as {cs, ras, cas, we} (active low)
//   - mode register word (CL = 2, burst length 1, sequential)
//   - client word-address field bounds (bank / row / column)
//   - state and operation enums used by the controller and its init sequencer
// -----------------------------------------------------------------------------
package sdram_pkg;

    typedef logic [3:0] sd_cmd_t;

    localparam sd_cmd_t CMD_INHIBIT   = 4'b1111;
    localparam sd_cmd_t CMD_NOP       = 4'b0111;
    localparam sd_cmd_t CMD_ACTIVE    = 4'b0011;
    localparam sd_cmd_t CMD_READ      = 4'b0101;
    localparam sd_cmd_t CMD_WRITE     = 4'b0100;
    localparam sd_cmd_t CMD_PRECHARGE = 4'b0010;
    localparam sd_cmd_t CMD_REFRESH   = 4'b0001;
    localparam sd_cmd_t CMD_LOAD_MODE = 4'b0000;

    // CL = 2, burst length 1, sequential burst type.
    localparam logic [10:0] MODE_WORD = 11'h020;

    // Client word address layout: bank = [19], row = [18:8], col = [7:0].
    localparam int BANK_BIT = 19;
    localparam int ROW_MSB  = 18;
    localparam int ROW_LSB  = 8;
    localparam int COL_MSB  = 7;
    localparam int COL_LSB  = 0;

    typedef enum logic [2:0] {
        ST_WAIT,
        ST_PRECHARGE,
        ST_REFRESH1,
        ST_REFRESH2,
        ST_LOAD_MODE,
        ST_IDLE
    } init_state_t;

    // Kind of access carried by the current 8-cycle window.
    typedef enum logic [1:0] {
        OP_REFRESH,
        OP_WRITE,
        OP_READ
    } win_op_t;

endpackage

// File: rtl/sdram_init_seq.sv
// -----------------------------------------------------------------------------
// sdram_init_seq
// Power-up sequencer for the SDRAM: waits INIT_WAIT cycles, precharges all
// banks, issues two auto refreshes and loads the mode register.
//
// Ports:
//   clk   in   SDRAM clock
//   init  in   synchronous active-high reset; restarts the sequence
//   cmd   out  command to be registered onto the pins at the next edge
//   addr  out  address to be registered onto the pins at the next edge
//   done  out  registered; high once the sequence has completed
//
// Each step issues its command in its first cycle (cnt == 0) and NOPs for the
// rest of the step, so step lengths double as the command spacing:
// PRECHARGE 3 cycles, each REFRESH 8 cycles, LOAD MODE 3 cycles.
// -----------------------------------------------------------------------------
module sdram_init_seq
    import sdram_pkg::*;
#(
    parameter int INIT_WAIT = 6400
) (
    input  logic        clk,
    input  logic        init,
    output sd_cmd_t     cmd,
    output logic [10:0] addr,
    output logic        done
);

    localparam logic [15:0] LAST_WAIT = 16'(INIT_WAIT - 1);

    init_state_t state;
    logic [15:0] cnt;

    always_comb begin
        cmd  = CMD_NOP;
        addr = '0;
        if (cnt == 16'd0) begin
            case (state)
                ST_PRECHARGE: begin
                    cmd  = CMD_PRECHARGE;
                    addr = 11'h400;          // A10 = 1: all banks
                end
                ST_REFRESH1,
                ST_REFRESH2: cmd = CMD_REFRESH;
                ST_LOAD_MODE: begin
                    cmd  = CMD_LOAD_MODE;
                    addr = MODE_WORD;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (init) begin
            state <= ST_WAIT;
            cnt   <= '0;
            done  <= 1'b0;
        end else begin
            case (state)
                ST_WAIT: begin
                    if (cnt == LAST_WAIT) begin
                        state <= ST_PRECHARGE;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                ST_PRECHARGE: begin
                    if (cnt == 16'd2) begin
                        state <= ST_REFRESH1;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                ST_REFRESH1: begin
                    if (cnt == 16'd7) begin
                        state <= ST_REFRESH2;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                ST_REFRESH2: begin
                    if (cnt == 16'd7) begin
                        state <= ST_LOAD_MODE;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                ST_LOAD_MODE: begin
                    if (cnt == 16'd2) begin
                        state <= ST_IDLE;
                        cnt   <= '0;
                        done  <= 1'b1;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                ST_IDLE: ;
                default: begin
                    state <= ST_WAIT;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/sdram_sync_ctrl.sv
// -----------------------------------------------------------------------------
// sdram_sync_ctrl
// Single-port SDRAM controller for a 16-bit, 2-bank, 11-bit-address part.
// Each sync pulse opens one 8-cycle window carrying one READ, WRITE or
// AUTO REFRESH.
//
// Ports:
//   clk          in   64 MHz SDRAM clock
//   init         in   synchronous active-high reset
//   sync         in   window strobe
//   we, oe       in   write / read request (write wins), sampled with sync
//   ds[1:0]      in   byte enables, [1] = upper byte
//   addr[19:0]   in   word address: bank [19], row [18:8], col [7:0]
//   din[15:0]    in   write data
//   dout[15:0]   out  read data, held until the next read capture
//   ready        out  high once the power-up sequence has completed
//   sd_data_in   in   pad input data
//   sd_data_out  out  pad output data
//   sd_data_dir  out  pad output enable
//   sd_addr, sd_ba, sd_dqm, sd_cs/ras/cas/we  out  SDRAM pins
//
// Request handshake: a sync pulse is accepted only when ready is high and no
// window is open (q == 0); the request fields are latched on that edge.
// A sync at any other time is dropped, there is no queue and no backpressure
// signal, so the client must space syncs at least 8 cycles apart.
//
// Window timeline relative to the accepting edge E0 (q counts 1..7 after it):
//   E0    ACTIVE (bank, row) or AUTO REFRESH for an idle window
//   E0+2  READ/WRITE with auto-precharge; write data driven for one cycle
//   E0+CAPTURE_PHASE  read data captured into dout
//   E0+7  q returns to 0, so a sync at E0+8 is accepted
// -----------------------------------------------------------------------------
module sdram_sync_ctrl
    import sdram_pkg::*;
#(
    parameter int INIT_WAIT     = 6400,
    parameter int CAPTURE_PHASE = 5
) (
    input  logic        clk,
    input  logic        init,
    input  logic        sync,
    input  logic        we,
    input  logic        oe,
    input  logic [1:0]  ds,
    input  logic [19:0] addr,
    input  logic [15:0] din,
    output logic [15:0] dout,
    output logic        ready,
    input  logic [15:0] sd_data_in,
    output logic [15:0] sd_data_out,
    output logic        sd_data_dir,
    output logic [10:0] sd_addr,
    output logic        sd_ba,
    output logic [1:0]  sd_dqm,
    output logic        sd_cs,
    output logic        sd_ras,
    output logic        sd_cas,
    output logic        sd_we
);

    localparam logic [2:0] CAP_Q = 3'(CAPTURE_PHASE);

    sd_cmd_t     init_cmd;
    logic [10:0] init_addr;
    logic        init_done;

    sdram_init_seq #(
        .INIT_WAIT (INIT_WAIT)
    ) u_init_seq (
        .clk  (clk),
        .init (init),
        .cmd  (init_cmd),
        .addr (init_addr),
        .done (init_done)
    );

    // The sequencer's done flop is the ready output directly, so ready rises
    // two cycles after LOAD MODE appears on the pins.
    assign ready = init_done;

    sd_cmd_t     cmd_q;
    logic [2:0]  q;
    win_op_t     op;
    logic [1:0]  ds_l;
    logic        bank_l;
    logic [7:0]  col_l;
    logic [15:0] din_l;

    assign {sd_cs, sd_ras, sd_cas, sd_we} = cmd_q;

    always_ff @(posedge clk) begin
        if (init) begin
            cmd_q       <= CMD_INHIBIT;
            sd_addr     <= '0;
            sd_ba       <= 1'b0;
            sd_dqm      <= 2'b11;
            sd_data_dir <= 1'b0;
            sd_data_out <= '0;
            dout        <= '0;
            q           <= '0;
            op          <= OP_REFRESH;
            ds_l        <= '0;
            bank_l      <= 1'b0;
            col_l       <= '0;
            din_l       <= '0;
        end else if (!init_done) begin
            // Power-up: the sequencer owns the pins, client requests dropped.
            cmd_q       <= init_cmd;
            sd_addr     <= init_addr;
            sd_ba       <= 1'b0;
            sd_dqm      <= 2'b11;
            sd_data_dir <= 1'b0;
        end else begin
            cmd_q       <= CMD_NOP;
            sd_dqm      <= 2'b11;
            sd_data_dir <= 1'b0;
            if (q == 3'd0) begin
                if (sync) begin
                    ds_l   <= ds;
                    bank_l <= addr[BANK_BIT];
                    col_l  <= addr[COL_MSB:COL_LSB];
                    din_l  <= din;
                    q      <= 3'd1;
                    if (we || oe) begin
                        op      <= we ? OP_WRITE : OP_READ;
                        cmd_q   <= CMD_ACTIVE;
                        sd_ba   <= addr[BANK_BIT];
                        sd_addr <= addr[ROW_MSB:ROW_LSB];
                    end else begin
                        op    <= OP_REFRESH;
                        cmd_q <= CMD_REFRESH;
                    end
                end
            end else begin
                // 3-bit counter wraps 7 -> 0, closing the window.
                q <= q + 3'd1;
                if (q == 3'd2 && op != OP_REFRESH) begin
                    sd_addr <= {1'b1, 2'b00, col_l};   // A10 = auto-precharge
                    sd_ba   <= bank_l;
                    sd_dqm  <= ~ds_l;
                    if (op == OP_WRITE) begin
                        cmd_q       <= CMD_WRITE;
                        sd_data_out <= din_l;
                        sd_data_dir <= 1'b1;
                    end else begin
                        cmd_q <= CMD_READ;
                    end
                end
                // Masked bytes are captured as they appear on the bus.
                if (q == CAP_Q && op == OP_READ) begin
                    dout <= sd_data_in;
                end
            end
        end
    end

endmodule

// File: tb/tb_sdram_sync_ctrl.sv
// -----------------------------------------------------------------------------
// tb_sdram_sync_ctrl
// Directed + randomized bench for sdram_sync_ctrl. A pin-level SDRAM model
// (open row per bank, CL = 2 read data) answers the controller, and a
// word-level reference memory keyed by client address predicts read data.
// -----------------------------------------------------------------------------
module tb_sdram_sync_ctrl;

  localparam int INIT_WAIT     = 6400;
  localparam int CAPTURE_PHASE = 5;

  localparam logic [3:0] C_INHIBIT = 4'b1111;
  localparam logic [3:0] C_NOP     = 4'b0111;
  localparam logic [3:0] C_ACTIVE  = 4'b0011;
  localparam logic [3:0] C_READ    = 4'b0101;
  localparam logic [3:0] C_WRITE   = 4'b0100;
  localparam logic [3:0] C_PRE     = 4'b0010;
  localparam logic [3:0] C_REF     = 4'b0001;
  localparam logic [3:0] C_LMR     = 4'b0000;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        init = 1'b1;
  logic        sync = 1'b0;
  logic        we = 1'b0;
  logic        oe = 1'b0;
  logic [1:0]  ds = 2'b00;
  logic [19:0] addr = '0;
  logic [15:0] din = '0;
  logic [15:0] dout;
  logic        ready;
  logic [15:0] sd_data_in = '0;
  logic [15:0] sd_data_out;
  logic        sd_data_dir;
  logic [10:0] sd_addr;
  logic        sd_ba;
  logic [1:0]  sd_dqm;
  logic        sd_cs, sd_ras, sd_cas, sd_we;
  logic [3:0]  cmd;

  assign cmd = {sd_cs, sd_ras, sd_cas, sd_we};

  sdram_sync_ctrl #(
    .INIT_WAIT     (INIT_WAIT),
    .CAPTURE_PHASE (CAPTURE_PHASE)
  ) dut (
    .clk         (clk),
    .init        (init),
    .sync        (sync),
    .we          (we),
    .oe          (oe),
    .ds          (ds),
    .addr        (addr),
    .din         (din),
    .dout        (dout),
    .ready       (ready),
    .sd_data_in  (sd_data_in),
    .sd_data_out (sd_data_out),
    .sd_data_dir (sd_data_dir),
    .sd_addr     (sd_addr),
    .sd_ba       (sd_ba),
    .sd_dqm      (sd_dqm),
    .sd_cs       (sd_cs),
    .sd_ras      (sd_ras),
    .sd_cas      (sd_cas),
    .sd_we       (sd_we)
  );

  // ---------------- pin-level SDRAM model ----------------
  logic [10:0] open_row [2];
  logic [15:0] pin_mem [logic [19:0]];
  logic [19:0] pm_key;
  logic [15:0] pm_cur;
  logic [15:0] rd_data = '0;
  int          rd_wait = 0;

  // Read data is valid on the bus only for the one cycle CL = 2 after the
  // READ is seen; every other cycle carries junk.
  always @(negedge clk) begin
    if (rd_wait == 1) sd_data_in = rd_data;
    else sd_data_in = 16'($urandom);
    if (rd_wait > 0) rd_wait = rd_wait - 1;
    case (cmd)
      C_ACTIVE: open_row[sd_ba] = sd_addr;
      C_WRITE: begin
        pm_key = {sd_ba, open_row[sd_ba], sd_addr[7:0]};
        pm_cur = pin_mem.exists(pm_key) ? pin_mem[pm_key] : 16'h0000;
        if (!sd_dqm[0]) pm_cur[7:0] = sd_data_out[7:0];
        if (!sd_dqm[1]) pm_cur[15:8] = sd_data_out[15:8];
        if (sd_data_dir) pin_mem[pm_key] = pm_cur;
      end
      C_READ: begin
        pm_key  = {sd_ba, open_row[sd_ba], sd_addr[7:0]};
        rd_data = pin_mem.exists(pm_key) ? pin_mem[pm_key] : 16'h0000;
        rd_wait = 2;
      end
      default: ;
    endcase
  end

  // ---------------- scoreboard ----------------
  int          tests = 0;
  int          fails = 0;
  logic [15:0] exp_q [$];
  logic [15:0] ref_mem [logic [19:0]];
  logic [15:0] exp_dout = '0;
  logic [19:0] ra [6];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Releases init and follows the power-up sequence, pulsing sync with write
  // requests throughout to confirm they are dropped.
  task automatic run_init(input string tag);
    int pre_c = -1, ref1 = -1, ref2 = -1, lmr = -1, rdy = -1, bad = 0, nops = 0;
    logic pre_a10 = 1'b0;
    logic [10:0] lmr_addr = '1;
    init = 1'b0;
    for (int c = 1; c <= INIT_WAIT + 100 && rdy < 0; c++) begin
      sync = (c % 8 == 3);
      we   = 1'b1;
      oe   = 1'b0;
      addr = 20'($urandom);
      tick();
      sync = 1'b0;
      if (ready) rdy = c;
      case (cmd)
        C_NOP: if (pre_c < 0) nops++;
        C_PRE: if (pre_c < 0) begin pre_c = c; pre_a10 = sd_addr[10]; end else bad++;
        C_REF: if (ref1 < 0) ref1 = c; else if (ref2 < 0) ref2 = c; else bad++;
        C_LMR: if (lmr < 0) begin lmr = c; lmr_addr = sd_addr; end else bad++;
        default: bad++;
      endcase
    end
    we = 1'b0;
    chk({tag, " nop_count"}, nops, INIT_WAIT);
    chk({tag, " precharge_cycle"}, pre_c, INIT_WAIT + 1);
    chk({tag, " precharge_a10"}, pre_a10, 1);
    chk({tag, " refresh1_cycle"}, ref1, pre_c + 3);
    chk({tag, " refresh2_cycle"}, ref2, ref1 + 8);
    chk({tag, " load_mode_cycle"}, lmr, ref2 + 8);
    chk({tag, " load_mode_addr"}, lmr_addr, 11'h020);
    chk({tag, " ready_cycle"}, rdy, lmr + 2);
    chk({tag, " unexpected_cmds"}, bad, 0);
    chk({tag, " dout"}, dout, 16'h0000);
  endtask

  // One window from the accepting edge (k = 0) to E0+7. extra_k pulses a
  // second sync mid-window; abort_k raises init at that edge.
  task automatic do_window(input string tag, input logic w, input logic r,
                           input logic [1:0] d, input logic [19:0] a,
                           input logic [15:0] di, input int extra_k, input int abort_k);
    logic is_wr, is_rd;
    logic [3:0] ecmd;
    logic [1:0] edqm;
    logic edir;
    logic [15:0] cur;
    is_wr = w;
    is_rd = r & ~w;
    we = w; oe = r; ds = d; addr = a; din = di;
    if (is_wr) begin
      cur = ref_mem.exists(a) ? ref_mem[a] : 16'h0000;
      if (d[0]) cur[7:0] = di[7:0];
      if (d[1]) cur[15:8] = di[15:8];
      ref_mem[a] = cur;
    end
    if (is_rd) exp_q.push_back(ref_mem.exists(a) ? ref_mem[a] : 16'h0000);
    chk($sformatf("%s ready", tag), ready, 1);
    for (int k = 0; k < 8; k++) begin
      sync = (k == 0) || (k == extra_k);
      if (k > 0) begin
        we = 1'b1; oe = 1'b0;
        ds = 2'($urandom); addr = 20'($urandom); din = 16'($urandom);
      end
      if (k == abort_k) init = 1'b1;
      tick();
      sync = 1'b0;
      if (k == abort_k) begin
        chk($sformatf("%s abort cmd", tag), cmd, C_INHIBIT);
        chk($sformatf("%s abort ready", tag), ready, 0);
        chk($sformatf("%s abort dout", tag), dout, 16'h0000);
        chk($sformatf("%s abort dir", tag), sd_data_dir, 0);
        chk($sformatf("%s abort dqm", tag), sd_dqm, 2'b11);
        if (is_rd) void'(exp_q.pop_back());
        exp_dout = 16'h0000;
        we = 1'b0;
        return;
      end
      ecmd = C_NOP; edqm = 2'b11; edir = 1'b0;
      if (k == 0) ecmd = (w || r) ? C_ACTIVE : C_REF;
      if (k == 2 && is_wr) begin ecmd = C_WRITE; edqm = ~d; edir = 1'b1; end
      if (k == 2 && is_rd) begin ecmd = C_READ; edqm = ~d; end
      chk($sformatf("%s cmd k%0d", tag, k), cmd, ecmd);
      chk($sformatf("%s dqm k%0d", tag, k), sd_dqm, edqm);
      chk($sformatf("%s dir k%0d", tag, k), sd_data_dir, edir);
      if (k == 0 && (w || r)) begin
        chk($sformatf("%s act ba", tag), sd_ba, a[19]);
        chk($sformatf("%s act row", tag), sd_addr, a[18:8]);
      end
      if (k == 2 && (w || r)) begin
        chk($sformatf("%s rw ba", tag), sd_ba, a[19]);
        chk($sformatf("%s rw col_a10", tag), sd_addr, {1'b1, 2'b00, a[7:0]});
      end
      if (k == 2 && is_wr) chk($sformatf("%s wdata", tag), sd_data_out, di);
      if (k == 4) chk($sformatf("%s dout hold", tag), dout, exp_dout);
      if (k == 6 && is_rd) begin
        exp_dout = exp_q.pop_front();
        chk($sformatf("%s dout", tag), dout, exp_dout);
      end
      if (k == 7) chk($sformatf("%s dout end", tag), dout, exp_dout);
    end
    we = 1'b0; oe = 1'b0;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    init = 1'b1;
    repeat (3) tick();
    chk("reset cmd", cmd, C_INHIBIT);
    chk("reset sd_addr", sd_addr, 11'h000);
    chk("reset sd_ba", sd_ba, 0);
    chk("reset dqm", sd_dqm, 2'b11);
    chk("reset dir", sd_data_dir, 0);
    chk("reset data_out", sd_data_out, 16'h0000);
    chk("reset dout", dout, 16'h0000);
    chk("reset ready", ready, 0);

    run_init("init1");

    do_window("wr_beef", 1, 0, 2'b11, 20'h81234, 16'hBEEF, -1, -1);
    do_window("rd_beef", 0, 1, 2'b11, 20'h81234, 16'h0000, -1, -1);
    do_window("wr_mask", 1, 0, 2'b01, 20'h81234, 16'h1234, -1, -1);
    do_window("rd_mask", 0, 1, 2'b11, 20'h81234, 16'h0000, -1, -1);
    chk("mask merged", exp_dout, 16'hBE34);
    do_window("idle", 0, 0, 2'b11, 20'h00000, 16'h0000, -1, -1);
    do_window("b2b", 1, 0, 2'b10, 20'h00ABC, 16'h5A5A, 4, -1);
    do_window("b2b_next", 0, 1, 2'b11, 20'h00ABC, 16'h0000, -1, -1);
    do_window("wr_both", 1, 1, 2'b11, 20'h7FFFF, 16'hC3C3, -1, -1);
    do_window("rd_both", 0, 1, 2'b11, 20'h7FFFF, 16'h0000, -1, -1);

    for (int i = 0; i < 6; i++) begin
      ra[i] = 20'($urandom);
      do_window($sformatf("rwr%0d", i), 1, 0, 2'($urandom_range(1, 3)), ra[i],
                16'($urandom), -1, -1);
      if ($urandom_range(0, 1) == 1)
        do_window($sformatf("ridle%0d", i), 0, 0, 2'b11, 20'h00000, 16'h0000, -1, -1);
    end
    for (int i = 0; i < 6; i++) begin
      do_window($sformatf("rrd%0d", i), 0, 1, 2'($urandom), ra[i], 16'h0000, -1, -1);
    end

    do_window("abort", 0, 1, 2'b11, 20'h81234, 16'h0000, -1, 3);
    run_init("init2");
    do_window("rd_after_init", 0, 1, 2'b11, 20'h81234, 16'h0000, -1, -1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
